program_loader: RTL and testbench

//   Byte-stream writer for the 4096 x 20-bit instruction memory; the write-side counterpart of its read-only fetch port.

---
 rtl/program_loader.sv | 171 +++++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction memory: assembles 20-bit words,
// writes one word per WRITE cycle from BASE_ADDR, and validates length and XOR checksum.
module program_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [19:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_N = (32'd1 << ADDR_W) - BASE_ADDR;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [19:0]       wdata_q, wdata_d;
    logic [12:0]       rem_q, rem_d;
    logic [7:0]        acc_q, acc_d;
    logic [4:0]        len_hi_q, len_hi_d;
    logic [3:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [12:0]       n_word;

    assign n_word = {len_hi_q, rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= ADDR_W'(BASE_ADDR);
            wdata_q  <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            len_hi_q <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            len_hi_q <= len_hi_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        len_hi_d = len_hi_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        rx_ready = 1'b0;
        busy     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    acc_d   = '0;
                end
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    len_hi_d = rx_data[4:0];
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (n_word == 13'd0 || 32'(n_word) > MAX_N) begin
                        state_d = S_ERROR;
                    end else begin
                        rem_d   = n_word;
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        state_d = S_ERROR;
                    end else begin
                        b0_d    = rx_data[3:0];
                        acc_d   = acc_q ^ rx_data;
                        state_d = S_B1;
                    end
                end
            end
            S_B1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    b1_d    = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    wdata_d = {b0_q, b1_q, rx_data};
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy  = 1'b1;
                rem_d = rem_q - 13'd1;
                // Address only advances when another word follows, so a full-depth
                // load leaves mem_addr on the last word instead of wrapping to 0.
                if (rem_q == 13'd1) begin
                    state_d = S_CSUM;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_B0;
                end
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    state_d = (rx_data == acc_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A WRITE cycle that coincides with reset must not reach the memory.
    assign mem_we    = (state_q == S_WRITE) && !reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frames are built in queues, a whole-frame reference
// model predicts the writes and the outcome, and captured mem_we cycles are compared.
module tb_program_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BASE   = 0;

    logic              clk = 1'b0;
    logic              reset, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, mem_we, busy, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [19:0]       mem_wdata;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frm[$];
    logic [31:0] exp_w[$];
    logic [31:0] got_w[$];
    bit          exp_done, exp_err;

    always @(negedge clk) begin
        #1;
        if (mem_we) got_w.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: interpret the whole frame by the protocol rules.
    task automatic model_frame();
        int unsigned n;
        logic [7:0]  hi, acc, b0, b1, b2;
        exp_w.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        hi = frm[0];
        n  = {19'd0, hi[4:0], frm[1]};
        if (n < 1 || n > (2**ADDR_W) - BASE) begin
            exp_err = 1'b1;
            return;
        end
        acc = 8'h00;
        for (int unsigned w = 0; w < n; w++) begin
            b0 = frm[2 + 3*w];
            b1 = frm[3 + 3*w];
            b2 = frm[4 + 3*w];
            if (b0[7:4] != 4'h0) begin
                exp_err = 1'b1;
                return;
            end
            acc = acc ^ b0 ^ b1 ^ b2;
            exp_w.push_back({12'(BASE + w), b0[3:0], b1, b2});
        end
        if (frm[2 + 3*n] == acc) exp_done = 1'b1;
        else                     exp_err  = 1'b1;
    endtask

    task automatic build_rand(input int unsigned nfield, input int nw, input int bad_idx, input bit bad_csum);
        logic [7:0]  x, b0;
        logic [19:0] w;
        logic [12:0] nf;
        nf = 13'(nfield);
        frm.delete();
        frm.push_back({3'($urandom), nf[12:8]});
        frm.push_back(nf[7:0]);
        x = 8'h00;
        for (int i = 0; i < nw; i++) begin
            w  = 20'($urandom);
            b0 = {4'h0, w[19:16]};
            if (i == bad_idx) b0[7:4] = 4'(1 + $urandom_range(0, 14));
            frm.push_back(b0);
            frm.push_back(w[15:8]);
            frm.push_back(w[7:0]);
            x = x ^ b0 ^ w[15:8] ^ w[7:0];
        end
        frm.push_back(bad_csum ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: toggling, 2: random (+ stray starts), 3: toggling with a 5-cycle gap
    task automatic send(input int unsigned maxb, input int mode);
        int unsigned idx, cyc, budget;
        bit          v;
        idx = 0;
        cyc = 0;
        budget = 10*maxb + 50;
        while (idx < maxb) begin
            @(negedge clk);
            if (!busy || cyc >= budget) break;
            cyc++;
            case (mode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = cyc[0] && !(cyc >= 10 && cyc < 15);
            endcase
            rx_valid = v;
            rx_data  = v ? frm[idx] : 8'($urandom);
            if (mode == 2) start = ($urandom_range(0, 7) == 0);
            if (v && rx_ready) idx++;
        end
        if (idx == maxb) @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        chk("send_budget", 32'(cyc >= budget), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            if (got_w[i] !== exp_w[i]) bad++;
        chk({tag, "_wdata"}, 32'(bad), 32'd0);
    endtask

    task automatic finish_check(input string tag);
        @(negedge clk);
        #2;
        chk({tag, "_done"},  32'(done),  32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_busy"},  32'(busy),  32'd0);
        check_writes(tag);
    endtask

    task automatic run_frame(input string tag, input int mode);
        model_frame();
        got_w.delete();
        do_start();
        send(frm.size(), mode);
        finish_check(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_error"},    32'(error),    32'd0);
        chk({tag, "_addr"},     32'(mem_addr), 32'(BASE));
        chk({tag, "_wdata"},    32'(mem_wdata), 32'd0);
    endtask

    task automatic load_t1();
        frm = {8'h00, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45,
               8'h0A ^ 8'hBC ^ 8'hDE ^ 8'h01 ^ 8'h23 ^ 8'h45};
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check_reset_vals("reset");

        // Basic two-word load with known words.
        load_t1();
        run_frame("t1", 0);
        chk("t1_w0", got_w[0], {12'h000, 20'hABCDE});
        chk("t1_w1", got_w[1], {12'h001, 20'h12345});

        // Same frame under gapped rx_valid.
        run_frame("t2_toggle", 1);
        run_frame("t2_gap", 3);

        // Illegal lengths.
        frm = {8'h00, 8'h00};
        run_frame("t3_len0", 0);
        frm = {8'h10, 8'h01};
        run_frame("t3_len4097", 0);

        // Bad high nibble in second word.
        frm = {8'h00, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'h1F, 8'h23, 8'h45, 8'h00};
        run_frame("t4_badb0", 0);

        // Full-depth load, then a bad-checksum variant.
        build_rand(4096, 4096, -1, 1'b0);
        run_frame("t5_full", 0);
        chk("t5_last_addr", 32'(mem_addr), 32'hFFF);
        build_rand(4096, 4096, -1, 1'b1);
        run_frame("t5_badcsum", 0);

        // Reset after B1 of the third word.
        build_rand(5, 5, -1, 1'b0);
        model_frame();
        while (exp_w.size() > 2) void'(exp_w.pop_back());
        got_w.delete();
        do_start();
        send(10, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_reset_vals("t6_rst");
        repeat (5) @(negedge clk);
        check_writes("t6_partial");
        load_t1();
        run_frame("t6_reload", 0);
        chk("t6_reload_w0", got_w[0], {12'h000, 20'hABCDE});

        // Reset landing on a WRITE cycle suppresses the strobe.
        build_rand(3, 3, -1, 1'b0);
        got_w.delete();
        do_start();
        send(5, 0);
        reset = 1'b1;
        #1;
        chk("t7_we_suppressed", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("t7_nwrites", 32'(got_w.size()), 32'd0);

        // Randomized frames with random faults, gaps and stray starts.
        for (int k = 0; k < 8; k++) begin
            int unsigned n, kind;
            n    = $urandom_range(1, 12);
            kind = $urandom_range(0, 3);
            case (kind)
                0: build_rand(n, n, -1, 1'b0);
                1: build_rand(n, n, -1, 1'b1);
                2: build_rand(n, n, $urandom_range(0, n - 1), 1'b0);
                default: build_rand(0, 0, -1, 1'b0);
            endcase
            run_frame($sformatf("rand%0d", k), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
